reg_file_rename: RTL and testbench

- Architectural register file with per-register rename tags; sits between the ROB and the Decoder.
- Stores 32 committed register values. Each register has a busy bit and a ROB tag naming the in-flight producer.
- Decoder reads rs1/rs2 through it to get either a committed value or a ROB tag; the tag is what the ROB uses for its own ready/value lookup.
- Accepts rename updates at issue, commit writes at retire, and a global flush on branch mispredict.

---
 rtl/reg_file_rename_pkg.sv | 17 +
 rtl/reg_file_rd_port.sv | 40 ++++
 rtl/reg_file_rename.sv | 98 +++++++++
 tb/tb_reg_file_rename.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_rename_pkg.sv
// Shared widths and constants for the rename-tagged architectural register file.
// Every other file in this block imports this package.
package reg_file_rename_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int ROB_IDX_W = 4;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  localparam logic [XLEN-1:0]      null32 = '0;
  localparam logic [REG_IDX_W-1:0] null5  = '0;
  localparam logic [ROB_IDX_W-1:0] null4  = '0;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: returns busy/value/tag for a source register.
// A matching same-cycle commit is forwarded so the decoder sees the fresh value.
module reg_file_rd_port
  import reg_file_rename_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs_id,
  input  logic                 reg_busy,
  input  logic [ROB_IDX_W-1:0] reg_tag,
  input  logic [XLEN-1:0]      reg_val,
  input  logic                 write_flag,
  input  logic [ROB_IDX_W-1:0] write_idx,
  input  logic [REG_IDX_W-1:0] write_rd,
  input  logic [XLEN-1:0]      new_val,
  output logic                 rs_busy,
  output logic [XLEN-1:0]      rs_val,
  output logic [ROB_IDX_W-1:0] rs_idx
);

  logic bypass;

  assign bypass = write_flag && (write_rd == rs_id) && (rs_id != null5) &&
                  reg_busy && (reg_tag == write_idx);

  always_comb begin
    rs_busy = False;
    rs_val  = null32;
    rs_idx  = null4;
    if (rs_id != null5) begin
      rs_idx = reg_tag;
      if (bypass) begin
        rs_busy = False;
        rs_val  = new_val;
      end else begin
        rs_busy = reg_busy;
        rs_val  = reg_val;
      end
    end
  end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register busy bit and ROB producer tag.
// Handles rename at issue, commit at retire and a mispredict flush.
module reg_file_rename
  import reg_file_rename_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 jp_wrong,
  input  logic [REG_IDX_W-1:0] rs1_ID,
  input  logic [REG_IDX_W-1:0] rs2_ID,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [XLEN-1:0]      rs1_val,
  output logic [XLEN-1:0]      rs2_val,
  output logic [ROB_IDX_W-1:0] rs1_idx,
  output logic [ROB_IDX_W-1:0] rs2_idx,
  input  logic                 upd_flag,
  input  logic [ROB_IDX_W-1:0] upd_idx,
  input  logic [REG_IDX_W-1:0] upd_rd,
  input  logic                 write_flag,
  input  logic [ROB_IDX_W-1:0] write_idx,
  input  logic [REG_IDX_W-1:0] write_rd,
  input  logic [XLEN-1:0]      new_val
);

  logic [NUM_REGS-1:0][XLEN-1:0]      value_q, value_d;
  logic [NUM_REGS-1:0]                busy_q,  busy_d;
  logic [NUM_REGS-1:0][ROB_IDX_W-1:0] tag_q,   tag_d;

  logic commit_en;
  logic rename_en;

  assign commit_en = write_flag && (write_rd != null5);
  assign rename_en = upd_flag && (upd_rd != null5);

  // A flush drops every in-flight mapping but still retires the committing value.
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (jp_wrong) begin
      busy_d = '0;
      if (commit_en) value_d[write_rd] = new_val;
    end else if (rdy) begin
      if (commit_en) begin
        value_d[write_rd] = new_val;
        if ((tag_q[write_rd] == write_idx) && !(rename_en && (upd_rd == write_rd)))
          busy_d[write_rd] = False;
      end
      if (rename_en) begin
        busy_d[upd_rd] = True;
        tag_d[upd_rd]  = upd_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  reg_file_rd_port u_rd_port1 (
    .rs_id      (rs1_ID),
    .reg_busy   (busy_q[rs1_ID]),
    .reg_tag    (tag_q[rs1_ID]),
    .reg_val    (value_q[rs1_ID]),
    .write_flag (write_flag),
    .write_idx  (write_idx),
    .write_rd   (write_rd),
    .new_val    (new_val),
    .rs_busy    (rs1_busy),
    .rs_val     (rs1_val),
    .rs_idx     (rs1_idx)
  );

  reg_file_rd_port u_rd_port2 (
    .rs_id      (rs2_ID),
    .reg_busy   (busy_q[rs2_ID]),
    .reg_tag    (tag_q[rs2_ID]),
    .reg_val    (value_q[rs2_ID]),
    .write_flag (write_flag),
    .write_idx  (write_idx),
    .write_rd   (write_rd),
    .new_val    (new_val),
    .rs_busy    (rs2_busy),
    .rs_val     (rs2_val),
    .rs_idx     (rs2_idx)
  );

endmodule

// File: tb/tb_reg_file_rename.sv
// Self-checking bench for reg_file_rename: directed vector table, an async
// reset sequence, then randomized traffic against an array-based reference model.
module tb_reg_file_rename;
  import reg_file_rename_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 rdy;
  logic                 jp_wrong;
  logic [REG_IDX_W-1:0] rs1_ID, rs2_ID;
  logic                 rs1_busy, rs2_busy;
  logic [XLEN-1:0]      rs1_val, rs2_val;
  logic [ROB_IDX_W-1:0] rs1_idx, rs2_idx;
  logic                 upd_flag;
  logic [ROB_IDX_W-1:0] upd_idx;
  logic [REG_IDX_W-1:0] upd_rd;
  logic                 write_flag;
  logic [ROB_IDX_W-1:0] write_idx;
  logic [REG_IDX_W-1:0] write_rd;
  logic [XLEN-1:0]      new_val;

  reg_file_rename dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .jp_wrong   (jp_wrong),
    .rs1_ID     (rs1_ID),
    .rs2_ID     (rs2_ID),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .upd_flag   (upd_flag),
    .upd_idx    (upd_idx),
    .upd_rd     (upd_rd),
    .write_flag (write_flag),
    .write_idx  (write_idx),
    .write_rd   (write_rd),
    .new_val    (new_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, jp, uf;
    logic [3:0]  ui;
    logic [4:0]  ur;
    logic        wf;
    logic [3:0]  wi;
    logic [4:0]  wr;
    logic [31:0] nv;
    logic [4:0]  r1;
    logic        eb1;
    logic [31:0] ev1;
    logic [3:0]  ei1;
    logic [4:0]  r2;
    logic        eb2;
    logic [31:0] ev2;
    logic [3:0]  ei2;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: one entry per architectural register.
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  task automatic add(input logic r, input logic j, input logic uf, input logic [3:0] ui,
                     input logic [4:0] ur, input logic wf, input logic [3:0] wi,
                     input logic [4:0] wr, input logic [31:0] nv,
                     input logic [4:0] r1, input logic eb1, input logic [31:0] ev1,
                     input logic [3:0] ei1, input logic [4:0] r2, input logic eb2,
                     input logic [31:0] ev2, input logic [3:0] ei2);
    vec_t v;
    v.rdy = r;  v.jp = j;   v.uf = uf;  v.ui = ui;  v.ur = ur;
    v.wf = wf;  v.wi = wi;  v.wr = wr;  v.nv = nv;
    v.r1 = r1;  v.eb1 = eb1; v.ev1 = ev1; v.ei1 = ei1;
    v.r2 = r2;  v.eb2 = eb2; v.ev2 = ev2; v.ei2 = ei2;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    rdy = v.rdy;  jp_wrong = v.jp;
    upd_flag = v.uf;  upd_idx = v.ui;  upd_rd = v.ur;
    write_flag = v.wf;  write_idx = v.wi;  write_rd = v.wr;  new_val = v.nv;
    rs1_ID = v.r1;  rs2_ID = v.r2;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    chk({tag, ".rs1_busy"}, {31'd0, rs1_busy}, {31'd0, v.eb1});
    chk({tag, ".rs1_val"},  rs1_val,           v.ev1);
    chk({tag, ".rs1_idx"},  {28'd0, rs1_idx},  {28'd0, v.ei1});
    chk({tag, ".rs2_busy"}, {31'd0, rs2_busy}, {31'd0, v.eb2});
    chk({tag, ".rs2_val"},  rs2_val,           v.ev2);
    chk({tag, ".rs2_idx"},  {28'd0, rs2_idx},  {28'd0, v.ei2});
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endfunction

  // Expected read: x0 is hard zero; a commit that retires the current producer forwards its value.
  function automatic void model_read(input vec_t v, input logic [4:0] id, output logic b,
                                     output logic [31:0] val, output logic [3:0] idx);
    b = 1'b0; val = '0; idx = '0;
    if (id != 0) begin
      idx = m_tag[id];
      if (v.wf && v.wr == id && m_busy[id] && m_tag[id] == v.wi) begin
        b = 1'b0; val = v.nv;
      end else begin
        b = m_busy[id]; val = m_val[id];
      end
    end
  endfunction

  function automatic void model_step(input vec_t v);
    if (v.jp) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      if (v.wf && v.wr != 0) m_val[v.wr] = v.nv;
    end else if (v.rdy) begin
      if (v.wf && v.wr != 0) begin
        m_val[v.wr] = v.nv;
        if (m_tag[v.wr] == v.wi && !(v.uf && v.ur == v.wr)) m_busy[v.wr] = 1'b0;
      end
      if (v.uf && v.ur != 0) begin
        m_busy[v.ur] = 1'b1;
        m_tag[v.ur]  = v.ui;
      end
    end
  endfunction

  initial begin
    vec_t v;
    rst = 1'b1;
    rdy = 1'b1; jp_wrong = 1'b0; upd_flag = 1'b0; upd_idx = '0; upd_rd = '0;
    write_flag = 1'b0; write_idx = '0; write_rd = '0; new_val = '0;
    rs1_ID = '0; rs2_ID = '0;

    //   rdy jp uf ui  ur wf wi  wr nv            r1 b  v             i   r2 b  v             i
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            5, 0, 0,            0,  0, 0, 0,            0);
    add(1, 0, 1, 3,  5, 0, 0,  0, 0,            5, 0, 0,            0,  0, 0, 0,            0);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            5, 1, 0,            3,  0, 0, 0,            0);
    add(1, 0, 0, 0,  0, 1, 3,  5, 32'hDEADBEEF, 5, 0, 32'hDEADBEEF, 3,  5, 0, 32'hDEADBEEF, 3);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            5, 0, 32'hDEADBEEF, 3,  0, 0, 0,            0);
    add(1, 0, 1, 2,  7, 0, 0,  0, 0,            7, 0, 0,            0,  0, 0, 0,            0);
    add(1, 0, 1, 9,  7, 0, 0,  0, 0,            7, 1, 0,            2,  0, 0, 0,            0);
    add(1, 0, 0, 0,  0, 1, 2,  7, 32'h11,       7, 1, 0,            9,  0, 0, 0,            0);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            7, 1, 32'h11,       9,  0, 0, 0,            0);
    add(1, 0, 1, 4,  8, 0, 0,  0, 0,            8, 0, 0,            0,  0, 0, 0,            0);
    add(1, 0, 1, 6,  8, 1, 4,  8, 32'h22,       8, 0, 32'h22,       4,  0, 0, 0,            0);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            8, 1, 32'h22,       6,  0, 0, 0,            0);
    add(1, 0, 1, 1,  1, 0, 0,  0, 0,            1, 0, 0,            0,  0, 0, 0,            0);
    add(1, 0, 1, 2,  2, 0, 0,  0, 0,            1, 1, 0,            1,  0, 0, 0,            0);
    add(1, 0, 1, 5,  3, 0, 0,  0, 0,            2, 1, 0,            2,  1, 1, 0,            1);
    add(1, 1, 1, 7,  4, 1, 2,  2, 32'h33,       2, 0, 32'h33,       2,  3, 1, 0,            5);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            2, 0, 32'h33,       2,  4, 0, 0,            0);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            1, 0, 0,            1,  3, 0, 0,            5);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            7, 0, 32'h11,       9,  8, 0, 32'h22,       6);
    add(1, 0, 1, 10, 1, 0, 0,  0, 0,            1, 0, 0,            1,  0, 0, 0,            0);
    add(1, 0, 1, 11, 2, 0, 0,  0, 0,            1, 1, 0,            10, 0, 0, 0,            0);
    add(0, 1, 1, 12, 4, 1, 11, 2, 32'h44,       2, 0, 32'h44,       11, 1, 1, 0,            10);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            2, 0, 32'h44,       11, 1, 0, 0,            10);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            4, 0, 0,            0,  3, 0, 0,            5);
    add(1, 0, 1, 13, 0, 1, 0,  0, 32'h55,       0, 0, 0,            0,  0, 0, 0,            0);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            0, 0, 0,            0,  0, 0, 0,            0);
    add(0, 0, 1, 14, 9, 0, 0,  0, 0,            9, 0, 0,            0,  0, 0, 0,            0);
    add(0, 0, 1, 14, 9, 1, 0,  10, 32'h66,      9, 0, 0,            0,  10, 0, 0,           0);
    add(1, 0, 1, 14, 9, 0, 0,  0, 0,            9, 0, 0,            0,  10, 0, 0,           0);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            9, 1, 0,            14, 10, 0, 0,           0);
    add(1, 0, 1, 15, 10, 1, 14, 9, 32'h77,      9, 0, 32'h77,       14, 10, 0, 0,           0);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0,            9, 0, 32'h77,       14, 10, 1, 0,           15);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset must clear a busy register before any clock edge.
    @(negedge clk);
    v = vecs[0];
    v.uf = 1'b1; v.ui = 4'd3; v.ur = 5'd5; v.r1 = 5'd5; v.r2 = 5'd9;
    applyStimulus(v);
    @(negedge clk);
    upd_flag = 1'b0;
    #1;
    chk("pre_rst.rs1_busy", {31'd0, rs1_busy}, 32'd1);
    chk("pre_rst.rs1_idx",  {28'd0, rs1_idx},  32'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_rst.rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("async_rst.rs1_val",  rs1_val,           32'd0);
    chk("async_rst.rs1_idx",  {28'd0, rs1_idx},  32'd0);
    chk("async_rst.rs2_val",  rs2_val,           32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic over a few registers so collisions and tag matches are frequent.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      v.rdy = ($urandom_range(0, 9) != 0);
      v.jp  = ($urandom_range(0, 19) == 0);
      v.uf  = $urandom_range(0, 1);
      v.ui  = 4'($urandom);
      v.ur  = 5'($urandom_range(0, 7));
      v.wf  = $urandom_range(0, 1);
      v.wr  = 5'($urandom_range(0, 7));
      v.wi  = ($urandom_range(0, 3) != 0) ? m_tag[v.wr] : 4'($urandom);
      v.nv  = $urandom;
      v.r1  = ($urandom_range(0, 1) != 0) ? v.wr : 5'($urandom_range(0, 7));
      v.r2  = 5'($urandom_range(0, 7));
      model_read(v, v.r1, v.eb1, v.ev1, v.ei1);
      model_read(v, v.r2, v.eb2, v.ev2, v.ei2);
      applyStimulus(v);
      #1;
      checkOutput($sformatf("rnd%0d", n), v);
      @(posedge clk);
      model_step(v);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
